issue_select: RTL and testbench
===============================

Name: issue_select

Overview:
- Issue-side consumer of the reservation-station interface.
- Each cycle it scans the RS contents, picks up to ISSUE_WIDTH ready entries using rotating priority, and returns a one-hot-per-entry grant vector so the RS frees those slots.
- Latches the granted packets into the issue/execute pipeline register, handling execute back-pressure and branch squash/resolve.

Parameters:
- RS_SZ, `RS_SZ, number of RS entries scanned.
- ISSUE_WIDTH, `N, maximum entries issued per cycle.
- PTR_W, $clog2(RS_SZ), width of the rotating priority pointer.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RS_data  in  RS_PACKET[RS_SZ]  full RS contents; fields used: Source1_ready, Source2_ready, b_mask.
- rs_valid  in  RS_SZ  per-entry occupied bit from the RS.
- ex_stall  in  1  1 = execute cannot accept; hold the pipeline register.
- b_mm_resolve  in  B_MASK  one-hot branch mask being resolved this cycle (0 = none).
- b_mm_mispred  in  1  1 = the resolving branch mispredicted.
- rs_data_issuing  out  RS_SZ  combinational grant vector back to the RS; bit i = entry i issues this cycle.
- issue_packets  out  RS_PACKET[ISSUE_WIDTH]  registered packets to execute.
- issue_valid  out  ISSUE_WIDTH  registered valid per issue slot.

Behaviour:
- Reset (reset==0, asynchronous): issue_valid=0, issue_packets='0, priority pointer ptr=0.
- rs_data_issuing is 0 while reset is asserted.
- Ready: ready[i] = rs_valid[i] & Source1_ready & Source2_ready & ~kill[i], where kill[i] = b_mm_mispred & |(RS_data[i].b_mask & b_mm_resolve).
- Selection (combinational):
  - Scan indices ptr, ptr+1, … wrapping mod RS_SZ.
  - Grant the first min(ISSUE_WIDTH, popcount(ready)) ready entries.
  - Slot k receives the k-th grant in scan order; unused slots are invalid.
- Stall: if ex_stall=1, rs_data_issuing=0, and issue_packets, issue_valid and ptr hold.
- Exception during stall: a held slot whose b_mask hits a mispredicting b_mm_resolve has its issue_valid cleared.
- Capture (ex_stall=0, rising edge):
  - issue_packets[k] <= granted packet; issue_valid[k] <= slot k granted.
  - Packets enter the register with b_mask already cleared of b_mm_resolve if !b_mm_mispred.
- Branch resolve on the registered stage, every cycle, stall or not:
  - mispred: clear issue_valid[k] where |(issue_packets[k].b_mask & b_mm_resolve).
  - correct: clear that bit in every issue_packets[k].b_mask.
- Pointer: after any cycle with ≥1 grant and no stall, ptr <= (index of last grant + 1) mod RS_SZ. With no grants, ptr holds.
- Wrap: scan order across index RS_SZ-1 → 0 is continuous. A grant set may straddle the wrap.
- Empty (no ready entries): grant vector 0, issue_valid=0 next edge (unless stalled), ptr holds.
- Full ready (all RS_SZ ready): exactly ISSUE_WIDTH grants, starting at ptr.
- rs_data_issuing never has more than ISSUE_WIDTH bits set and never sets a bit where rs_valid=0.
- Reset mid-operation: asynchronous clear of all state regardless of ex_stall or pending grants. The first post-reset selection starts at index 0.
- Latency: grant is same-cycle combinational; packet is visible at the execute input one edge later.

Test Plan (RS_SZ=8, ISSUE_WIDTH=2):
- Reset asserted mid-stream with issue_valid=2'b11 → outputs clear immediately without a clock edge. After release, with entries 3,5 ready: grant=8'b0010_1000, slots hold entries 3,5, ptr=6.
- ptr=6, ready entries {7,0,4} → grant=8'b1000_0001, slot0=entry7, slot1=entry0, ptr=1. Next cycle, same entries still ready except 7,0 freed → grant=8'b0001_0000, ptr=5.
- Entry 2 valid with Source2_ready=0 only → grant=0, issue_valid=0. Set Source2_ready=1 → grant=8'b0000_0100.
- ex_stall=1 for 3 cycles with 4 ready entries → grant=0 each cycle, issue_packets and ptr unchanged. Release → 2 grants that same cycle.
- Slot0 b_mask=4'b0010 registered. Apply b_mm_resolve=4'b0010, mispred=1 → issue_valid[0]=0 next edge. Ready RS entry with the same mask is not granted.
- Correct resolve b_mm_resolve=4'b0100 on a slot with b_mask=4'b0110 → b_mask=4'b0010 and issue_valid unchanged, both while stalled and while not stalled.

Source files
------------

// File: rtl/issue_select.sv
// Issue select: rotating-priority pick of up to ISSUE_WIDTH ready RS entries
// into the issue/execute register, with stall hold and branch squash/resolve.
package issue_pkg;
  localparam int B_MASK = 4;

  typedef struct packed {
    logic [15:0]       tag;
    logic              Source1_ready;
    logic              Source2_ready;
    logic [B_MASK-1:0] b_mask;
  } RS_PACKET;
endpackage

module issue_select
  import issue_pkg::*;
#(
  parameter int RS_SZ       = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int PTR_W       = $clog2(RS_SZ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  RS_PACKET [RS_SZ-1:0]       RS_data,
  input  logic [RS_SZ-1:0]           rs_valid,
  input  logic                       ex_stall,
  input  logic [B_MASK-1:0]          b_mm_resolve,
  input  logic                       b_mm_mispred,
  output logic [RS_SZ-1:0]           rs_data_issuing,
  output RS_PACKET [ISSUE_WIDTH-1:0] issue_packets,
  output logic [ISSUE_WIDTH-1:0]     issue_valid
);

  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

  logic [PTR_W-1:0]       r_ptr;
  logic [RS_SZ-1:0]       w_ready;
  logic [RS_SZ-1:0]       w_grant;
  logic [PTR_W-1:0]       w_sel_idx [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] w_sel_v;
  logic [PTR_W-1:0]       w_last;
  logic [PTR_W-1:0]       w_nptr;

  RS_PACKET [ISSUE_WIDTH-1:0] w_hold_pkt;
  RS_PACKET [ISSUE_WIDTH-1:0] w_new_pkt;
  logic [ISSUE_WIDTH-1:0]     w_hold_v;

  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      w_ready[i] = rs_valid[i]
                 & RS_data[i].Source1_ready
                 & RS_data[i].Source2_ready
                 & ~(b_mm_mispred
                     & |(RS_data[i].b_mask & b_mm_resolve));
    end
  end

  // Walk from r_ptr with wrap; the n-th ready entry lands in slot n.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    w_grant = '0;
    w_sel_v = '0;
    w_last  = '0;
    cnt     = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_sel_idx[k] = '0;
    end
    for (int j = 0; j < RS_SZ; j++) begin
      sum = {1'b0, r_ptr} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(RS_SZ)) begin
        sum = sum - (PTR_W+1)'(RS_SZ);
      end
      idx = sum[PTR_W-1:0];
      if (w_ready[idx] && (cnt < CNT_W'(ISSUE_WIDTH))) begin
        w_grant[idx] = 1'b1;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          if (cnt == CNT_W'(k)) begin
            w_sel_idx[k] = idx;
            w_sel_v[k]   = 1'b1;
          end
        end
        w_last = idx;
        cnt    = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    if (w_last == PTR_W'(RS_SZ - 1)) begin
      w_nptr = '0;
    end else begin
      w_nptr = w_last + PTR_W'(1);
    end
  end

  assign rs_data_issuing = (reset && !ex_stall) ? w_grant : '0;

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_hold_pkt[k] = issue_packets[k];
      w_hold_v[k]   = issue_valid[k];
      if (b_mm_mispred) begin
        if (|(issue_packets[k].b_mask & b_mm_resolve)) begin
          w_hold_v[k] = 1'b0;
        end
      end else begin
        w_hold_pkt[k].b_mask = issue_packets[k].b_mask & ~b_mm_resolve;
      end
      w_new_pkt[k] = w_sel_v[k] ? RS_data[w_sel_idx[k]] : '0;
      if (!b_mm_mispred) begin
        w_new_pkt[k].b_mask = w_new_pkt[k].b_mask & ~b_mm_resolve;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_packets <= '0;
      issue_valid   <= '0;
      r_ptr         <= '0;
    end else if (ex_stall) begin
      issue_packets <= w_hold_pkt;
      issue_valid   <= w_hold_v;
    end else begin
      issue_packets <= w_new_pkt;
      issue_valid   <= w_sel_v;
      if (|w_sel_v) begin
        r_ptr <= w_nptr;
      end
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios plus random traffic
// against a queue-based selection model.
module tb_issue_select;
  import issue_pkg::*;

  localparam int RS = 8;
  localparam int W  = 2;

  logic                clock;
  logic                reset;
  RS_PACKET [RS-1:0]   RS_data;
  logic [RS-1:0]       rs_valid;
  logic                ex_stall;
  logic [B_MASK-1:0]   b_mm_resolve;
  logic                b_mm_mispred;
  logic [RS-1:0]       rs_data_issuing;
  RS_PACKET [W-1:0]    issue_packets;
  logic [W-1:0]        issue_valid;

  issue_select #(.RS_SZ(RS), .ISSUE_WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .RS_data        (RS_data),
    .rs_valid       (rs_valid),
    .ex_stall       (ex_stall),
    .b_mm_resolve   (b_mm_resolve),
    .b_mm_mispred   (b_mm_mispred),
    .rs_data_issuing(rs_data_issuing),
    .issue_packets  (issue_packets),
    .issue_valid    (issue_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  int       m_ptr;
  logic     m_v [W];
  RS_PACKET m_pkt [W];
  int       mq[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0;
    for (int k = 0; k < W; k++) begin
      m_v[k]   = 1'b0;
      m_pkt[k] = '0;
    end
  endtask

  // Ready entries in priority order, starting at the model pointer.
  task automatic m_select(output logic [RS-1:0] g);
    mq.delete();
    g = '0;
    for (int j = 0; j < RS; j++) begin
      int       idx;
      RS_PACKET e;
      bit       kill;
      idx  = (m_ptr + j) % RS;
      e    = RS_data[idx];
      kill = b_mm_mispred && ((e.b_mask & b_mm_resolve) != 0);
      if (rs_valid[idx] && e.Source1_ready && e.Source2_ready && !kill)
        mq.push_back(idx);
    end
    for (int k = 0; k < W && k < mq.size(); k++) g[mq[k]] = 1'b1;
  endtask

  task automatic m_update();
    int n;
    if (ex_stall) begin
      for (int k = 0; k < W; k++) begin
        if (b_mm_mispred) begin
          if ((m_pkt[k].b_mask & b_mm_resolve) != 0) m_v[k] = 1'b0;
        end else begin
          m_pkt[k].b_mask = m_pkt[k].b_mask & ~b_mm_resolve;
        end
      end
    end else begin
      n = (mq.size() < W) ? mq.size() : W;
      for (int k = 0; k < W; k++) begin
        if (k < n) begin
          m_pkt[k] = RS_data[mq[k]];
          if (!b_mm_mispred)
            m_pkt[k].b_mask = m_pkt[k].b_mask & ~b_mm_resolve;
          m_v[k] = 1'b1;
        end else begin
          m_v[k] = 1'b0;
        end
      end
      if (n > 0) m_ptr = (mq[n-1] + 1) % RS;
    end
  endtask

  task automatic step(bit use_exp, logic [RS-1:0] exp_g);
    logic [RS-1:0] g;
    logic [W-1:0]  ev;
    m_select(g);
    #1;
    chk("grant", rs_data_issuing, ex_stall ? '0 : g);
    if (use_exp) chk("dir_grant", rs_data_issuing, exp_g);
    @(posedge clock);
    m_update();
    #1;
    for (int k = 0; k < W; k++) ev[k] = m_v[k];
    chk("valid", issue_valid, ev);
    for (int k = 0; k < W; k++)
      if (m_v[k]) chk($sformatf("pkt%0d", k), issue_packets[k], m_pkt[k]);
    @(negedge clock);
  endtask

  task automatic set_rs(logic [RS-1:0] v);
    for (int i = 0; i < RS; i++) begin
      RS_data[i].tag           = 16'($urandom);
      RS_data[i].Source1_ready = 1'b1;
      RS_data[i].Source2_ready = 1'b1;
      RS_data[i].b_mask        = '0;
    end
    rs_valid     = v;
    ex_stall     = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
  endtask

  task automatic rand_in();
    for (int i = 0; i < RS; i++) begin
      RS_data[i].tag           = 16'($urandom);
      RS_data[i].Source1_ready = $urandom_range(0, 3) != 0;
      RS_data[i].Source2_ready = $urandom_range(0, 3) != 0;
      RS_data[i].b_mask        = 4'($urandom);
    end
    rs_valid     = 8'($urandom);
    ex_stall     = $urandom_range(0, 3) == 0;
    b_mm_resolve = $urandom_range(0, 1) ? (4'b1 << $urandom_range(0, 3)) : '0;
    b_mm_mispred = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    reset = 1'b0;
    set_rs('0);
    m_reset();
    #1;
    chk("rst_valid", issue_valid, '0);
    chk("rst_pkts", issue_packets, '0);
    chk("rst_grant", rs_data_issuing, '0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Fill both slots, then reset in the middle of the cycle.
    set_rs(8'hFF);
    step(1'b1, 8'b0000_0011);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", issue_valid, '0);
    chk("async_pkts", issue_packets, '0);
    chk("async_grant", rs_data_issuing, '0);
    m_reset();
    @(negedge clock);
    reset = 1'b1;

    set_rs(8'b0010_1000);
    step(1'b1, 8'b0010_1000);
    chk("slot0_e3", issue_packets[0], RS_data[3]);
    chk("slot1_e5", issue_packets[1], RS_data[5]);

    set_rs(8'b1001_0001);
    step(1'b1, 8'b1000_0001);
    chk("slot0_e7", issue_packets[0], RS_data[7]);
    chk("slot1_e0", issue_packets[1], RS_data[0]);
    set_rs(8'b0001_0000);
    step(1'b1, 8'b0001_0000);

    set_rs(8'b0000_0100);
    RS_data[2].Source2_ready = 1'b0;
    step(1'b1, 8'b0000_0000);
    chk("notready_v", issue_valid, '0);
    RS_data[2].Source2_ready = 1'b1;
    step(1'b1, 8'b0000_0100);

    set_rs(8'b1111_0000);
    ex_stall = 1'b1;
    for (int c = 0; c < 3; c++) step(1'b1, 8'b0000_0000);
    ex_stall = 1'b0;
    step(1'b1, 8'b0011_0000);

    // Squash of a held slot while stalled, then of a ready RS entry.
    set_rs(8'b0000_0010);
    RS_data[1].b_mask = 4'b0010;
    step(1'b1, 8'b0000_0010);
    ex_stall     = 1'b1;
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    step(1'b1, 8'b0000_0000);
    chk("stall_kill", issue_valid, '0);
    set_rs(8'b0100_0010);
    RS_data[1].b_mask = 4'b0010;
    b_mm_resolve      = 4'b0010;
    b_mm_mispred      = 1'b1;
    step(1'b1, 8'b0100_0000);

    set_rs(8'b0000_0010);
    RS_data[1].b_mask = 4'b0110;
    step(1'b1, 8'b0000_0010);
    ex_stall     = 1'b1;
    b_mm_resolve = 4'b0100;
    step(1'b1, 8'b0000_0000);
    chk("resolve_mask", issue_packets[0].b_mask, 4'b0010);
    chk("resolve_v", issue_valid, 2'b01);

    for (int c = 0; c < 400; c++) begin
      rand_in();
      step(1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
